cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
- Read hits return data in the same cycle without SRAM access. Read misses and all writes go to the SRAM controller's request/ready handshake.
- `ready` freezes the upstream pipeline while an SRAM transaction is outstanding.
- One cache line = one 32-bit word; byte address bits [1:0] are ignored.

Parameters:
- INDEX_W, 6, set-index width (2^INDEX_W sets; default 64 sets, 128 lines total).
- TAG_W (localparam), 16-INDEX_W, tag width. Default 10, taken from address[17:8].

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- rd_en  in  1  load request from MEM stage.
- wr_en  in  1  store request from MEM stage.
- address  in  32  byte address. index = address[INDEX_W+1:2], tag = address[17:INDEX_W+2].
- writeData  in  32  store data.
- readData  out  32  load data; valid when rd_en && ready.
- ready  out  1  0 = freeze pipeline.
- sram_rd_en  out  1  read request to SRAM controller.
- sram_wr_en  out  1  write request to SRAM controller.
- sram_address  out  32  equals address (combinational pass-through).
- sram_writeData  out  32  equals writeData (combinational pass-through).
- sram_readData  in  32  SRAM controller read data.
- sram_ready  in  1  SRAM controller ready.

Behaviour:
- Storage per set:
  - way0/way1: valid, tag[TAG_W], data[32].
  - One lru bit = the way to evict next.
- Reset: all valid=0, all lru=0, state=IDLE. Outputs: ready=1, sram_rd_en=0, sram_wr_en=0, readData=0.
- Reset mid-transaction: drop the SRAM request immediately. No line update. The SRAM controller shares rst.
- Hit detection (combinational): hitN = validN && tagN==tag; hit = hit0|hit1. hit0 and hit1 are never both 1.
- Priority: wr_en over rd_en when both are asserted. Neither asserted: ready=1, no state change.
- FSM:
  - IDLE:
    - rd_en && hit: ready=1, readData = data of the hit way. At the clock edge, lru <= ~hit_way. Stay IDLE. Read-hit latency = 0 extra cycles.
    - rd_en && !hit: ready=0. Go to READ_MISS.
    - wr_en: ready=0. Go to WRITE_THRU.
  - READ_MISS:
    - sram_rd_en=1. ready=0 until sram_ready=1.
    - Cycle with sram_ready=1: ready=1 and readData=sram_readData (forwarded).
    - At that edge, fill the victim way: way0 if !valid0; else way1 if !valid1; else the lru way. Set valid=1, tag, data; lru <= ~victim. Go to IDLE.
  - WRITE_THRU:
    - sram_wr_en=1. ready=0 until sram_ready=1; ready=1 in that cycle.
    - At that edge, if hit: the hit way's data <= writeData and lru <= ~hit_way.
    - On a miss, no allocation and lru unchanged. Go to IDLE.
- sram_rd_en/sram_wr_en are deasserted in the cycle after sram_ready is sampled high. They are never both high.
- Upstream holds address/writeData/rd_en/wr_en stable while ready=0. Changes while ready=0 are undefined.
- readData when not (rd_en && ready) is don't-care. The bench must not check it.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0], both reset to 0.
  - hit_count increments on each IDLE read hit.
  - miss_count increments on each READ_MISS completion.
  - Both counters wrap at 0xFFFF→0. Writes are not counted.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - state enum IDLE/READ_MISS/WRITE_THRU.
  - INDEX_W default, TAG_W derivation.
  - Address field slice helpers (index, tag).
- Sub-module cache_way_array, instantiated twice. Each instance holds valid/tag/data arrays and provides:
  - synchronous clear on rst;
  - combinational lookup (valid, tag, data) by index;
  - a write port (index, tag, data, we).
- FSM, lru bits and victim selection live in cache_controller.

Test Plan:
1. Cold read, address 0x0000_0104. Expect: ready=0, sram_rd_en=1 until the model's sram_ready (5 cycles later); readData=model value 0xDEAD_BEEF in the sram_ready cycle. Repeat read → ready=1 the same cycle, 0xDEAD_BEEF, sram_rd_en stays 0.
2. Same-set conflict:
   - Read 0x104, then 0x504, then 0x904 (index 1; tags 1, 5, 9).
   - Third fill evicts way0 (tag 1, LRU).
   - Then read 0x504 → hit; read 0x104 → miss.
3. Write hit: after 1, write 0x104 ← 0x1234_5678. Expect sram_wr_en=1 and sram_writeData=0x1234_5678 until sram_ready. Next read 0x104 → hit, 0x1234_5678.
4. Write miss to 0x2000 (no allocate). Expect SRAM write occurs; a subsequent read 0x2000 misses.
5. rd_en=wr_en=1 at 0x104 → write-through path taken (sram_wr_en=1, sram_rd_en=0). rst pulsed during READ_MISS → next cycle sram_rd_en=0, ready=1; read 0x104 then misses.
6. CACHE_STATS_EN: sequence 1 (1 miss, 1 hit) → miss_count=1, hit_count=1. Preload hit_count near 0xFFFF via 65535 hits → wraps to 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the 2-way write-through data cache.
package cache_pkg;
  localparam int INDEX_W_DEF = 6;
  localparam int LINE_ADDR_W = 16;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU} state_t;

  function automatic int tag_w(input int index_w);
    return LINE_ADDR_W - index_w;
  endfunction

  // Word address bits [17:2] form {tag, index}; callers truncate to their widths.
  function automatic logic [15:0] addr_index(input logic [31:0] addr, input int index_w);
    logic [15:0] line;
    line = addr[17:2];
    return line & ((16'(1) << index_w) - 16'(1));
  endfunction

  function automatic logic [15:0] addr_tag(input logic [31:0] addr, input int index_w);
    logic [15:0] line;
    line = addr[17:2];
    return line >> index_w;
  endfunction
endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid/tag/data per set, async lookup, single write port.
module cache_way_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  output logic               valid,
  output logic [TAG_W-1:0]   tag,
  output logic [31:0]        data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data
);
  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0]      data_q [SETS];

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (we) valid_q[wr_index] <= 1'b1;
  end

  // Tag/data need no reset: valid gates every lookup.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign valid = valid_q[index];
  assign tag   = tag_q[index];
  assign data  = data_q[index];
endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate cache in front of the SRAM controller.
// Optional CACHE_STATS_EN adds hit_count/miss_count outputs.
module cache_controller
  import cache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_writeData,
  input  logic [31:0] sram_readData,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int TAG_W = tag_w(INDEX_W);
  localparam int SETS  = 1 << INDEX_W;

  state_t state, state_nxt;
  logic [SETS-1:0]    lru;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               v0, v1, hit0, hit1, hit, victim;
  logic [TAG_W-1:0]   t0, t1;
  logic [31:0]        d0, d1, wr_data;
  logic               we0, we1, lru_we, lru_val, rd_hit, fill;

  assign index          = INDEX_W'(addr_index(address, INDEX_W));
  assign tag            = TAG_W'(addr_tag(address, INDEX_W));
  assign sram_address   = address;
  assign sram_writeData = writeData;

  cache_way_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst(rst), .index(index), .valid(v0), .tag(t0), .data(d0),
    .we(we0), .wr_index(index), .wr_tag(tag), .wr_data(wr_data));
  cache_way_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst(rst), .index(index), .valid(v1), .tag(t1), .data(d1),
    .we(we1), .wr_index(index), .wr_tag(tag), .wr_data(wr_data));

  assign hit0   = v0 && (t0 == tag);
  assign hit1   = v1 && (t1 == tag);
  assign hit    = hit0 | hit1;
  // Prefer an empty way before consulting lru.
  assign victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[index]);
  assign rd_hit = (state == IDLE) && rd_en && !wr_en && hit;
  assign fill   = (state == READ_MISS) && sram_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (wr_en) state_nxt = WRITE_THRU;
                  else if (rd_en && !hit) state_nxt = READ_MISS;
      READ_MISS:  if (sram_ready) state_nxt = IDLE;
      WRITE_THRU: if (sram_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // rst masks the SRAM request in the same cycle so a reset drops it at once.
  always_comb begin
    ready      = 1'b1;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    readData   = hit1 ? d1 : (hit0 ? d0 : '0);
    wr_data    = writeData;
    we0        = 1'b0;
    we1        = 1'b0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (wr_en || (rd_en && !hit)) ready = 1'b0;
          else if (rd_hit) begin
            lru_we  = 1'b1;
            lru_val = ~hit1;
          end
        end
        READ_MISS: begin
          sram_rd_en = 1'b1;
          ready      = sram_ready;
          readData   = sram_readData;
          wr_data    = sram_readData;
          if (fill) begin
            we0     = ~victim;
            we1     = victim;
            lru_we  = 1'b1;
            lru_val = ~victim;
          end
        end
        WRITE_THRU: begin
          sram_wr_en = 1'b1;
          ready      = sram_ready;
          if (sram_ready && hit) begin
            we0     = hit0;
            we1     = hit1;
            lru_we  = 1'b1;
            lru_val = ~hit1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lru <= '0;
    else if (lru_we) lru[index] <= lru_val;
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit) hit_count  <= hit_count + 16'd1;
      if (fill)   miss_count <= miss_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller with a fixed-latency SRAM model.
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] readData, sram_address, sram_writeData, sram_readData;
  logic        ready, sram_rd_en, sram_wr_en, sram_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
    .sram_writeData(sram_writeData), .sram_readData(sram_readData), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  localparam int LAT = 5;

  function automatic logic [31:0] init_val(input int i);
    return (i == 'h41) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  // SRAM model: ready pulses after LAT sampled request cycles.
  logic [31:0] sram_mem [0:4095];
  bit          init_done;
  int          cnt;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= init_val(i);
      init_done <= 1'b1;
    end
    if (rst) begin
      cnt <= 0;
      sram_ready <= 1'b0;
    end else if ((sram_rd_en || sram_wr_en) && !sram_ready) begin
      if (cnt == LAT - 1) begin
        cnt <= 0;
        sram_ready <= 1'b1;
        sram_readData <= sram_mem[sram_address[13:2]];
        if (sram_wr_en) sram_mem[sram_address[13:2]] <= sram_writeData;
      end else cnt <= cnt + 1;
    end else begin
      cnt <= 0;
      sram_ready <= 1'b0;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
  } vec_t;

  typedef struct {
    string       name;
    logic        is_rd;
    logic        exp_hit;
    logic [31:0] exp_data;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] ref_mem [0:4095];
  int          compared = 0, mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Called just after a posedge; leaves the bench just after a posedge.
  task automatic run_op(input string name, input vec_t v);
    sb_t  e, got_e;
    int   cyc;
    logic saw_rd, saw_wr, done;
    e.name     = name;
    e.is_rd    = v.rd && !v.wr;
    e.exp_hit  = v.exp_hit;
    e.exp_data = ref_mem[v.addr[13:2]];
    sb.push_back(e);
    rd_en = v.rd; wr_en = v.wr; address = v.addr; writeData = v.wdata;
    cyc = 0; saw_rd = 1'b0; saw_wr = 1'b0; done = 1'b0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (sram_rd_en) saw_rd = 1'b1;
      if (sram_wr_en) saw_wr = 1'b1;
      if (ready) done = 1'b1;
      else cyc++;
    end
    got_e = sb.pop_front();
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: ready stuck low, expected completion within 50 cycles", got_e.name);
    end else begin
      check({got_e.name, " hit"}, 32'(cyc == 0), 32'(got_e.exp_hit));
      if (got_e.is_rd) check({got_e.name, " data"}, readData, got_e.exp_data);
      check({got_e.name, " sram_rd"}, 32'(saw_rd), 32'(got_e.is_rd && !got_e.exp_hit));
      check({got_e.name, " sram_wr"}, 32'(saw_wr), 32'(v.wr));
      check({got_e.name, " sram_addr"}, sram_address, v.addr);
      if (v.wr) check({got_e.name, " sram_wdata"}, sram_writeData, v.wdata);
    end
    if (v.wr) ref_mem[v.addr[13:2]] = v.wdata;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check({got_e.name, " req_dropped"}, 32'(sram_rd_en | sram_wr_en), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[18];
  vec_t v;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    //            rd    wr    addr          wdata          hit
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0504, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0904, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0504, 32'h0,         1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_2003, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0104, 32'hA5A5_A5A5, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0904, 32'h0,         1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b1};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_0504, 32'h0,         1'b0};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b1};
    vecs[17] = '{1'b1, 1'b0, 32'h0000_0904, 32'h0,         1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", 32'(ready), 32'd1);
    check("reset sram_rd_en", 32'(sram_rd_en), 32'd0);
    check("reset sram_wr_en", 32'(sram_wr_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle ready", 32'(ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of a read miss drops the request and empties the cache.
    rd_en = 1'b1; address = 32'h0000_3004;
    repeat (3) @(negedge clk);
    check("rstseq req_active", 32'(sram_rd_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("rstseq sram_rd_en", 32'(sram_rd_en), 32'd0);
    check("rstseq ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0};
    run_op("rstseq reread", v);

`ifdef CACHE_STATS_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("stats reset hit", 32'(hit_count), 32'd0);
    check("stats reset miss", 32'(miss_count), 32'd0);
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0};
    run_op("stats miss", v);
    v.exp_hit = 1'b1;
    run_op("stats hit", v);
    check("stats hit_count", 32'(hit_count), 32'd1);
    check("stats miss_count", 32'(miss_count), 32'd1);
    rd_en = 1'b1; address = 32'h0000_0104;
    repeat (65535) @(posedge clk);
    #1; rd_en = 1'b0;
    @(negedge clk);
    check("stats hit wrap", 32'(hit_count), 32'd0);
    check("stats miss hold", 32'(miss_count), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
